regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Shares the single write port / single async read port of the 16x8 register
//  file between two requesters: port A (UART side) and port B (S100 bus side).
//  Round-robin arbitration, one transaction in flight, req/ack handshake.
//  After reset, sequences an init pass writing INIT_VALUE to every register.
// PARAMETERS
//  DATA_WIDTH  8                   register width
//  NUM_REGS    16                  number of registers
//  ADDR_WIDTH  $clog2(NUM_REGS)    register index width
//  INIT_VALUE  8'h00               value written to every register during init
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  reset      in   1           asynchronous, active-high reset
//  a_req      in   1           port A request (level, held until a_ack)
//  a_we       in   1           port A: 1=write, 0=read
//  a_addr     in   ADDR_WIDTH  port A register index
//  a_wdata    in   DATA_WIDTH  port A write data
//  a_ack      out  1           port A one-cycle completion pulse
//  a_rdata    out  DATA_WIDTH  port A read data, valid while a_ack=1
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata   same as port A, for port B
//  busy       out  1           1 during INIT and while a transaction is in flight
//  rf_we      out  1           to register file writeEn
//  rf_waddr   out  ADDR_WIDTH  to register file writeAddr
//  rf_wdata   out  DATA_WIDTH  to register file writeData
//  rf_raddr   out  ADDR_WIDTH  to register file readAddr
//  rf_rdata   in   DATA_WIDTH  from register file readData (combinational)
// BEHAVIOUR
//  Reset (async, any state): state=INIT, init counter=0, last_grant=B (so A
//   wins first tie), a_ack=b_ack=0, a_rdata=b_rdata=0, busy=1, rf_we=0,
//   rf_waddr=rf_raddr=0, rf_wdata=0. Transaction in flight is abandoned, no ack.
//  States: INIT, IDLE, ACCESS, ACK.
//  INIT: each cycle rf_we=1, rf_waddr=counter, rf_wdata=INIT_VALUE; counter
//   increments; after writing index NUM_REGS-1 -> IDLE (exactly NUM_REGS
//   cycles). Requests arriving during INIT are not acked; they stay pending.
//  IDLE: busy=0, rf_we=0. Sample a_req/b_req:
//   none -> stay; one -> grant it; both -> grant port != last_grant.
//   On grant: latch we/addr/wdata of winner, update last_grant, -> ACCESS.
//  ACCESS (1 cycle): rf_raddr=rf_waddr=latched addr; rf_we=latched we,
//   rf_wdata=latched wdata. Read: capture rf_rdata into winner's rdata at the
//   end of this cycle. Write: winner's rdata unchanged. -> ACK.
//  ACK (1 cycle): winner's ack=1, other ack=0, rf_we=0. -> IDLE.
//  Latency: req sampled high in IDLE at edge N -> ack high in cycle N+2;
//   next grant sampled no earlier than cycle N+3 (one transaction per 3 cycles).
//  Requester must drop req in the cycle after ack; a req still high in IDLE is
//   a new transaction. Request fields must be stable from req rise until ack.
//  Loser of a tie stays pending and is granted on the next IDLE cycle.
//  Read-after-write: write completes at end of ACCESS; any later read returns
//   new value. Same-address A write / B read tie: order follows round-robin.
//  Address wrap: addr >= NUM_REGS not possible at default params; for other
//   NUM_REGS, out-of-range indices are ignored (no write, rdata=0), still acked.
//  a_ack and b_ack are never high in the same cycle.
// TESTING
//  Reset release -> 16 INIT cycles, rf_we=1 addrs 0..15 data 00, busy falls
//   cycle 17; read of reg 7 by A returns 8'h00.
//  A writes 8'h5A to reg 3 -> a_ack 2 cycles after sampling; B read reg 3 ->
//   b_rdata=8'h5A with b_ack.
//  A and B req together from IDLE, 4 back-to-back each -> grants A,B,A,B,...,
//   acks never coincident, 8 acks total.
//  A req held during INIT -> no ack until INIT done; ack at 3rd cycle after IDLE entry.
//  Reset asserted in ACCESS of a B write of 8'hFF to reg 9 -> no b_ack,
//   INIT restarts, reg 9 reads 8'h00 afterwards.
//  Single requester streaming (req re-raised one cycle after ack) -> one ack every 3 cycles.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of a register file write/read port between two requesters, with a power-up init pass
module regfile_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  busy,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);
    localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, ACCESS = 2'd2, ACK = 2'd3;
    logic [1:0] state;
    logic [ADDR_WIDTH-1:0] initCnt, addrLatch;
    logic [DATA_WIDTH-1:0] wdataLatch;
    logic weLatch, grantB, lastGrantB, pickB, inRange;
    // B wins when it is the only requester, or on a tie when A was served last
    always_comb begin
        pickB = b_req && (!a_req || !lastGrantB);
        inRange = int'(addrLatch) < NUM_REGS;
        busy = state != IDLE;
        rf_we = state == INIT ? !reset : (state == ACCESS && weLatch && inRange);
        rf_waddr = state == INIT ? initCnt : addrLatch;
        rf_wdata = state == INIT ? INIT_VALUE : wdataLatch;
        rf_raddr = addrLatch;
        a_ack = state == ACK && !grantB;
        b_ack = state == ACK && grantB;
    end
    // init sweep, grant latching and read capture; reset abandons any transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            initCnt <= '0;
            lastGrantB <= 1'b1;
            grantB <= 1'b0;
            weLatch <= 1'b0;
            addrLatch <= '0;
            wdataLatch <= '0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            case (state)
                INIT: begin
                    initCnt <= int'(initCnt) == NUM_REGS - 1 ? '0 : initCnt + 1'b1;
                    state <= int'(initCnt) == NUM_REGS - 1 ? IDLE : INIT;
                end
                IDLE: if (a_req || b_req) begin
                    grantB <= pickB;
                    lastGrantB <= pickB;
                    weLatch <= pickB ? b_we : a_we;
                    addrLatch <= pickB ? b_addr : a_addr;
                    wdataLatch <= pickB ? b_wdata : a_wdata;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (!weLatch && grantB) b_rdata <= inRange ? rf_rdata : '0;
                    if (!weLatch && !grantB) a_rdata <= inRange ? rf_rdata : '0;
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scenario tests for regfile_arbiter against a behavioural 16x8 register file
module tb_regfile_arbiter;
    logic clk = 0, reset = 1;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic a_ack, b_ack, busy, rf_we;
    logic [7:0] a_rdata, b_rdata, rf_wdata, rf_rdata;
    logic [3:0] rf_waddr, rf_raddr;
    logic [7:0] rf [16];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    // behavioural register file: synchronous write, combinational read
    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf[rf_raddr];

    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    // one transaction on a port; lat = negedges from req raise to ack, -1 on timeout
    task automatic xact(input bit pb, input bit we, input logic [3:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int lat);
        @(negedge clk);
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (pb ? b_ack : a_ack) begin lat = i; break; end
        end
        rd = pb ? b_rdata : a_rdata;
        a_req = 0;
        b_req = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        @(negedge clk);
        total++;
        if (busy !== 1 || rf_we !== 0 || a_ack !== 0 || b_ack !== 0 || a_rdata !== 0 || b_rdata !== 0 ||
            rf_waddr !== 0 || rf_raddr !== 0 || rf_wdata !== 0) begin
            bad++;
            $display("FAIL reset_state got busy=%b we=%b acks=%b%b rd=%h/%h wa=%h ra=%h wd=%h exp busy=1 rest 0",
                     busy, rf_we, a_ack, b_ack, a_rdata, b_rdata, rf_waddr, rf_raddr, rf_wdata);
        end
        reset = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rf_we !== 1 || rf_waddr !== 4'(i) || rf_wdata !== 8'h00 || busy !== 1) begin
                bad++;
                $display("FAIL init_%0d got we=%b addr=%h data=%h busy=%b exp we=1 addr=%h data=00 busy=1",
                         i, rf_we, rf_waddr, rf_wdata, busy, 4'(i));
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (busy !== 0) begin bad++; $display("FAIL busy_fall got=%b exp=0", busy); end
    endtask

    task automatic test_read_write;
        logic [7:0] rd;
        int lat;
        xact(0, 0, 4'd7, 8'h00, rd, lat);
        total++;
        if (rd !== 8'h00 || lat !== 2) begin bad++; $display("FAIL a_read7 got rd=%h lat=%0d exp rd=00 lat=2", rd, lat); end
        xact(0, 1, 4'd3, 8'h5A, rd, lat);
        total++;
        if (lat !== 2 || rd !== 8'h00) begin bad++; $display("FAIL a_write3 got lat=%0d rd=%h exp lat=2 rd=00", lat, rd); end
        xact(1, 0, 4'd3, 8'h00, rd, lat);
        total++;
        if (rd !== 8'h5A || lat !== 2) begin bad++; $display("FAIL b_read3 got rd=%h lat=%0d exp rd=5a lat=2", rd, lat); end
    endtask

    task automatic test_back_to_back;
        int na = 0, nb = 0, nextB = 0, both = 0, lastT = -1;
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 4'd4; a_wdata = 8'h10;
        b_req = 1; b_we = 0; b_addr = 4'd4;
        for (int t = 0; t < 60 && na + nb < 8; t++) begin
            @(negedge clk);
            if (a_ack && b_ack) both++;
            if (a_ack || b_ack) begin
                if (lastT >= 0) begin
                    total++;
                    if (t - lastT !== 3) begin bad++; $display("FAIL tie_spacing got=%0d exp=3", t - lastT); end
                end
                lastT = t;
            end
            if (a_ack) begin
                total++;
                if (nextB !== 0) begin bad++; $display("FAIL tie_order got=A exp=B at ack %0d", na + nb); end
                nextB = 1;
                na++;
                a_wdata = 8'(8'h10 + na);
                if (na == 4) a_req = 0;
            end
            if (b_ack) begin
                total++;
                if (nextB !== 1 || b_rdata !== 8'(8'h10 + nb)) begin
                    bad++;
                    $display("FAIL tie_b_read got order_b=%0d rd=%h exp order_b=1 rd=%h", nextB, b_rdata, 8'(8'h10 + nb));
                end
                nextB = 0;
                nb++;
                if (nb == 4) b_req = 0;
            end
        end
        a_req = 0;
        b_req = 0;
        total++;
        if (na !== 4 || nb !== 4) begin bad++; $display("FAIL tie_count got a=%0d b=%0d exp 4/4", na, nb); end
        total++;
        if (both !== 0) begin bad++; $display("FAIL tie_coincident got=%0d exp=0", both); end
    endtask

    task automatic test_stream;
        int n = 0, lastT = -1;
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 4'd3;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (a_ack) begin
                total++;
                if (a_rdata !== 8'h5A) begin bad++; $display("FAIL stream_rd got=%h exp=5a", a_rdata); end
                if (lastT >= 0) begin
                    total++;
                    if (t - lastT !== 3) begin bad++; $display("FAIL stream_gap got=%0d exp=3", t - lastT); end
                end
                lastT = t;
                n++;
                if (n == 4) a_req = 0;
            end
        end
        a_req = 0;
        total++;
        if (n !== 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", n); end
    endtask

    task automatic test_init_hold;
        int idleT = -1, ackT = -1;
        logic [7:0] rd = 8'hXX;
        @(negedge clk);
        reset = 1;
        a_req = 1; a_we = 0; a_addr = 4'd3;
        @(negedge clk);
        reset = 0;
        #1;
        for (int t = 0; t < 40; t++) begin
            if (!busy && idleT < 0) idleT = t;
            if (a_ack && ackT < 0) begin ackT = t; rd = a_rdata; a_req = 0; end
            @(negedge clk);
            #1;
        end
        a_req = 0;
        total++;
        if (idleT !== 16) begin bad++; $display("FAIL hold_idle got=%0d exp=16", idleT); end
        total++;
        if (ackT !== 18 || rd !== 8'h00) begin bad++; $display("FAIL hold_ack got t=%0d rd=%h exp t=18 rd=00", ackT, rd); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rd;
        int lat, acks = 0;
        xact(1, 1, 4'd9, 8'h33, rd, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL pre_write9 got lat=%0d exp=2", lat); end
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 4'd9; b_wdata = 8'hFF;
        @(negedge clk);
        total++;
        if (rf_we !== 1 || rf_waddr !== 4'd9 || rf_wdata !== 8'hFF) begin
            bad++;
            $display("FAIL mid_access got we=%b addr=%h data=%h exp we=1 addr=9 data=ff", rf_we, rf_waddr, rf_wdata);
        end
        reset = 1;
        #1;
        total++;
        if (busy !== 1 || b_ack !== 0 || rf_we !== 0) begin
            bad++;
            $display("FAIL mid_reset got busy=%b ack=%b we=%b exp busy=1 ack=0 we=0", busy, b_ack, rf_we);
        end
        b_req = 0;
        @(negedge clk);
        reset = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b_ack) acks++;
        end
        total++;
        if (acks !== 0 || busy !== 0) begin bad++; $display("FAIL mid_no_ack got acks=%0d busy=%b exp 0/0", acks, busy); end
        xact(0, 0, 4'd9, 8'h00, rd, lat);
        total++;
        if (rd !== 8'h00 || lat !== 2) begin bad++; $display("FAIL mid_read9 got rd=%h lat=%0d exp rd=00 lat=2", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_back_to_back();
        test_stream();
        test_init_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
